// File: rtl/noc_pkg.sv
// Shared widths and the AXI-Stream flit record for the NoC packetizer.
package noc_pkg;

    localparam int NOC_DW  = 512;
    localparam int BYTE_DW = 8;
    localparam int USER_DW = 32;
    localparam int KEEP_W  = NOC_DW / BYTE_DW;

    typedef struct packed {
        logic [NOC_DW-1:0]  data;
        logic [KEEP_W-1:0]  strb;
        logic [KEEP_W-1:0]  keep;
        logic [BYTE_DW-1:0] id;
        logic [BYTE_DW-1:0] dest;
        logic [USER_DW-1:0] user;
        logic               last;
    } axis_flit_t;

endpackage

// File: rtl/noc_axis_out_slice.sv
// Registered AXI-Stream output stage; out_free_o says a new flit may load this cycle.
module noc_axis_out_slice
    import noc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       load_i,
    input  axis_flit_t flit_i,
    input  logic       m_tready_i,
    output logic       m_tvalid_o,
    output axis_flit_t flit_o,
    output logic       out_free_o
);

    logic       valid_q;
    axis_flit_t flit_q;

    // Loads only happen when out_free_o is high, so a load never overwrites an unsent flit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            flit_q  <= '0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            flit_q  <= flit_i;
        end else if (m_tready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign out_free_o = !valid_q || m_tready_i;
    assign m_tvalid_o = valid_q;
    assign flit_o     = flit_q;

endmodule

// File: rtl/noc_axis_packetizer.sv
// Packs DATA_W-bit words into NOC_DW-bit AXI-Stream flits with tkeep/tdest/tlast per packet.
// Define NOC_PACKETIZER_TUSER_SEQ_EN to carry a per-packet sequence number on m_tuser.
module noc_axis_packetizer
    import noc_pkg::*;
#(
    parameter int NOC_DW  = noc_pkg::NOC_DW,
    parameter int BYTE_DW = noc_pkg::BYTE_DW,
    parameter int USER_DW = noc_pkg::USER_DW,
    parameter int DATA_W  = 128
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_W-1:0]         in_data,
    input  logic                      in_last,
    input  logic [BYTE_DW-1:0]        in_dest,
    input  logic [BYTE_DW-1:0]        cfg_tid,
    output logic                      m_tvalid,
    input  logic                      m_tready,
    output logic [NOC_DW-1:0]         m_tdata,
    output logic [NOC_DW/BYTE_DW-1:0] m_tstrb,
    output logic [NOC_DW/BYTE_DW-1:0] m_tkeep,
    output logic [BYTE_DW-1:0]        m_tid,
    output logic [BYTE_DW-1:0]        m_tdest,
    output logic [USER_DW-1:0]        m_tuser,
    output logic                      m_tlast
);

    localparam int LANES  = NOC_DW / DATA_W;
    localparam int LIDX_W = $clog2(LANES);
    localparam int WORD_B = DATA_W / BYTE_DW;
    localparam int STRB_W = NOC_DW / BYTE_DW;

    logic [LIDX_W-1:0]  lane_idx_q, lane_idx_d;
    logic               in_pkt_q, in_pkt_d;
    logic [BYTE_DW-1:0] dest_q, dest_d;
    logic [NOC_DW-1:0]  buf_data_q, buf_data_d;
    logic [STRB_W-1:0]  buf_keep_q, buf_keep_d;

    logic               out_free;
    logic               completing;
    logic               accept;
    logic               load;
    logic [NOC_DW-1:0]  packed_data;
    logic [STRB_W-1:0]  packed_keep;
    logic [USER_DW-1:0] user_cur;
    axis_flit_t         flit_d;
    axis_flit_t         flit_q;

    always_comb begin
        completing  = (lane_idx_q == LIDX_W'(LANES - 1)) || in_last;
        // Only a completing beat needs the output register; partial beats never stall.
        in_ready    = completing ? out_free : 1'b1;
        accept      = in_valid && in_ready;
        load        = accept && completing;

        packed_data = buf_data_q;
        packed_keep = buf_keep_q;
        for (int l = 0; l < LANES; l++) begin
            if (lane_idx_q == LIDX_W'(l)) begin
                packed_data[l*DATA_W +: DATA_W] = in_data;
                packed_keep[l*WORD_B +: WORD_B] = '1;
            end
        end

        lane_idx_d = lane_idx_q;
        in_pkt_d   = in_pkt_q;
        dest_d     = dest_q;
        buf_data_d = buf_data_q;
        buf_keep_d = buf_keep_q;
        if (accept) begin
            if (!in_pkt_q) begin
                dest_d = in_dest;
            end
            in_pkt_d = !in_last;
            if (completing) begin
                lane_idx_d = '0;
                buf_data_d = '0;
                buf_keep_d = '0;
            end else begin
                lane_idx_d = lane_idx_q + 1'b1;
                buf_data_d = packed_data;
                buf_keep_d = packed_keep;
            end
        end

        flit_d      = '0;
        flit_d.data = packed_data;
        flit_d.strb = packed_keep;
        flit_d.keep = packed_keep;
        flit_d.id   = cfg_tid;
        flit_d.dest = in_pkt_q ? dest_q : in_dest;
        flit_d.user = user_cur;
        flit_d.last = in_last;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lane_idx_q <= '0;
            in_pkt_q   <= 1'b0;
            dest_q     <= '0;
            buf_data_q <= '0;
            buf_keep_q <= '0;
        end else begin
            lane_idx_q <= lane_idx_d;
            in_pkt_q   <= in_pkt_d;
            dest_q     <= dest_d;
            buf_data_q <= buf_data_d;
            buf_keep_q <= buf_keep_d;
        end
    end

`ifdef NOC_PACKETIZER_TUSER_SEQ_EN
    logic [USER_DW-1:0] seq_q, seq_d;

    // The count advances after the packet's last word, so every flit of a packet shares one value.
    always_comb begin
        seq_d = seq_q;
        if (accept && in_last) begin
            seq_d = seq_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seq_q <= '0;
        end else begin
            seq_q <= seq_d;
        end
    end

    assign user_cur = seq_q;
`else
    assign user_cur = '0;
`endif

    noc_axis_out_slice u_out_slice (
        .clk        (clk),
        .reset      (reset),
        .load_i     (load),
        .flit_i     (flit_d),
        .m_tready_i (m_tready),
        .m_tvalid_o (m_tvalid),
        .flit_o     (flit_q),
        .out_free_o (out_free)
    );

    assign m_tdata = flit_q.data;
    assign m_tstrb = flit_q.strb;
    assign m_tkeep = flit_q.keep;
    assign m_tid   = flit_q.id;
    assign m_tdest = flit_q.dest;
    assign m_tuser = flit_q.user;
    assign m_tlast = flit_q.last;

endmodule

// File: tb/tb_noc_axis_packetizer.sv
// Scoreboard bench for noc_axis_packetizer (NOC_DW=512, DATA_W=128, four lanes).
module tb_noc_axis_packetizer;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         in_last;
    logic [7:0]   in_dest;
    logic [7:0]   cfg_tid;
    logic         m_tvalid;
    logic         m_tready;
    logic [511:0] m_tdata;
    logic [63:0]  m_tstrb;
    logic [63:0]  m_tkeep;
    logic [7:0]   m_tid;
    logic [7:0]   m_tdest;
    logic [31:0]  m_tuser;
    logic         m_tlast;

    noc_axis_packetizer #(
        .NOC_DW  (512),
        .BYTE_DW (8),
        .USER_DW (32),
        .DATA_W  (128)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_last  (in_last),
        .in_dest  (in_dest),
        .cfg_tid  (cfg_tid),
        .m_tvalid (m_tvalid),
        .m_tready (m_tready),
        .m_tdata  (m_tdata),
        .m_tstrb  (m_tstrb),
        .m_tkeep  (m_tkeep),
        .m_tid    (m_tid),
        .m_tdest  (m_tdest),
        .m_tuser  (m_tuser),
        .m_tlast  (m_tlast)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [511:0] data;
        logic [63:0]  keep;
        logic [7:0]   dest;
        logic [31:0]  user;
        logic         last;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    localparam logic [63:0] KEEP_ALL = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] KEEP_2W  = 64'h0000_0000_FFFF_FFFF;
    localparam logic [63:0] KEEP_1W  = 64'h0000_0000_0000_FFFF;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [127:0] w(input logic [7:0] b);
        return {16{b}};
    endfunction

    function automatic logic [31:0] usr(input int n);
`ifdef NOC_PACKETIZER_TUSER_SEQ_EN
        return 32'(n);
`else
        return 32'(n) & 32'h0;
`endif
    endfunction

    task automatic push(input logic [511:0] d, input logic [63:0] k, input logic [7:0] dst,
                        input logic [31:0] u, input logic l);
        exp_t e;
        e.data = d; e.keep = k; e.dest = dst; e.user = u; e.last = l;
        exp_q.push_back(e);
    endtask

    task automatic send_word(input logic [127:0] d, input logic l, input logic [7:0] dst);
        bit ok;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        in_dest  = dst;
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            #4;
            if (in_ready) begin
                @(posedge clk);
                ok = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL send_timeout actual=not_accepted required=accepted word=%0h", d);
        end
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) begin
            @(negedge clk);
        end
        chk("drain_pending", 512'(exp_q.size()), 512'(0));
    endtask

    // Monitor: a flit transfers on the next posedge whenever valid and ready are both high mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (m_tvalid && m_tready && !reset) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_flit actual=%0h required=none", m_tdata);
                end else begin
                    e = exp_q.pop_front();
                    chk("tdata", m_tdata, e.data);
                    chk("tkeep", 512'(m_tkeep), 512'(e.keep));
                    chk("tstrb", 512'(m_tstrb), 512'(e.keep));
                    chk("tid",   512'(m_tid),   512'(8'h7E));
                    chk("tdest", 512'(m_tdest), 512'(e.dest));
                    chk("tuser", 512'(m_tuser), 512'(e.user));
                    chk("tlast", 512'(m_tlast), 512'(e.last));
                end
            end
        end
    end

    initial begin
        logic [511:0] exp_c;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        in_last  = 1'b0;
        in_dest  = '0;
        cfg_tid  = 8'h7E;
        m_tready = 1'b1;

        repeat (2) @(negedge clk);
        chk("rst_tvalid",  512'(m_tvalid), 512'(0));
        chk("rst_tdata",   m_tdata, 512'(0));
        chk("rst_tkeep",   512'(m_tkeep), 512'(0));
        chk("rst_tlast",   512'(m_tlast), 512'(0));
        chk("rst_inready", 512'(in_ready), 512'(1));
        @(negedge clk);
        reset = 1'b0;

        // Full four-word packet and one-cycle load latency
        push({w(8'hA3), w(8'hA2), w(8'hA1), w(8'hA0)}, KEEP_ALL, 8'h11, usr(0), 1'b1);
        send_word(w(8'hA0), 1'b0, 8'h11);
        send_word(w(8'hA1), 1'b0, 8'h11);
        send_word(w(8'hA2), 1'b0, 8'h11);
        chk("latency_early", 512'(m_tvalid), 512'(0));
        send_word(w(8'hA3), 1'b1, 8'h11);
        chk("latency_load", 512'(m_tvalid), 512'(1));
        wait_drain();

        // Six words: full flit then two-lane partial flit
        push({w(8'hB3), w(8'hB2), w(8'hB1), w(8'hB0)}, KEEP_ALL, 8'h22, usr(1), 1'b0);
        push({256'h0, w(8'hB5), w(8'hB4)}, KEEP_2W, 8'h22, usr(1), 1'b1);
        for (int i = 0; i < 6; i++) begin
            send_word(w(8'hB0 + 8'(i)), (i == 5), 8'h22);
        end
        wait_drain();

        // Backpressure: one flit held, the next completing word must stall
        @(negedge clk);
        m_tready = 1'b0;
        exp_c = {w(8'hC3), w(8'hC2), w(8'hC1), w(8'hC0)};
        push(exp_c, KEEP_ALL, 8'h33, usr(2), 1'b1);
        for (int i = 0; i < 4; i++) begin
            send_word(w(8'hC0 + 8'(i)), (i == 3), 8'h33);
        end
        push({w(8'hD3), w(8'hD2), w(8'hD1), w(8'hD0)}, KEEP_ALL, 8'h44, usr(3), 1'b0);
        push({w(8'hD7), w(8'hD6), w(8'hD5), w(8'hD4)}, KEEP_ALL, 8'h44, usr(3), 1'b1);
        for (int i = 0; i < 3; i++) begin
            send_word(w(8'hD0 + 8'(i)), 1'b0, 8'h44);
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = w(8'hD3);
        in_last  = 1'b0;
        in_dest  = 8'h44;
        for (int i = 0; i < 3; i++) begin
            #4;
            chk("stall_inready", 512'(in_ready), 512'(0));
            chk("hold_tvalid",   512'(m_tvalid), 512'(1));
            chk("hold_tdata",    m_tdata, exp_c);
            @(negedge clk);
        end
        in_valid = 1'b0;
        m_tready = 1'b1;
        for (int i = 3; i < 8; i++) begin
            send_word(w(8'hD0 + 8'(i)), (i == 7), 8'h44);
        end
        wait_drain();

        // tdest latched from the first word only
        push({w(8'hE3), w(8'hE2), w(8'hE1), w(8'hE0)}, KEEP_ALL, 8'h05, usr(4), 1'b0);
        push({w(8'hE7), w(8'hE6), w(8'hE5), w(8'hE4)}, KEEP_ALL, 8'h05, usr(4), 1'b1);
        push({384'h0, w(8'hF0)}, KEEP_1W, 8'h09, usr(5), 1'b1);
        send_word(w(8'hE0), 1'b0, 8'h05);
        for (int i = 1; i < 8; i++) begin
            send_word(w(8'hE0 + 8'(i)), (i == 7), 8'h09);
        end
        send_word(w(8'hF0), 1'b1, 8'h09);
        wait_drain();

        // Reset with a held flit and a half-built packet
        @(negedge clk);
        m_tready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send_word(w(8'h60 + 8'(i)), (i == 3), 8'h66);
        end
        send_word(w(8'h70), 1'b0, 8'h77);
        send_word(w(8'h71), 1'b0, 8'h77);
        chk("held_before_reset", 512'(m_tvalid), 512'(1));
        #2;
        reset = 1'b1;
        #1;
        chk("reset_async_tvalid", 512'(m_tvalid), 512'(0));
        chk("reset_async_tkeep",  512'(m_tkeep), 512'(0));
        @(negedge clk);
        @(negedge clk);
        reset    = 1'b0;
        m_tready = 1'b1;

        // Single-word packets after reset: lane 0, fresh keep, sequence restarts
        push({384'h0, w(8'h90)}, KEEP_1W, 8'h88, usr(0), 1'b1);
        push({384'h0, w(8'h91)}, KEEP_1W, 8'h89, usr(1), 1'b1);
        push({384'h0, w(8'h92)}, KEEP_1W, 8'h8A, usr(2), 1'b1);
        send_word(w(8'h90), 1'b1, 8'h88);
        send_word(w(8'h91), 1'b1, 8'h89);
        send_word(w(8'h92), 1'b1, 8'h8A);
        wait_drain();
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
